// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, in-order imem requests, fetch queue and IF/ID register.
// Define IF_PERF_CNT_EN to add the perf_fetch_cnt / perf_bubble_cnt outputs.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FBUF_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall_req,
    input  logic        ex_branch_flag,
    input  logic [31:0] ex_branch_addr,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
`ifdef IF_PERF_CNT_EN
    output logic        id_valid,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
`else
    output logic        id_valid
`endif
);

    localparam int unsigned PtrW = (FBUF_DEPTH > 1) ? $clog2(FBUF_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FBUF_DEPTH + 1);

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;
    typedef logic [CntW:0]   wcnt_t;

    logic [31:0] fetch_pc_q;
    logic [31:0] tag_q  [FBUF_DEPTH];
    logic [31:0] data_q [FBUF_DEPTH];
    ptr_t        head_q;
    ptr_t        fill_q;
    ptr_t        tail_q;
    cnt_t        filled_cnt_q;
    cnt_t        inflight_q;
    cnt_t        discard_q;

    logic        pop;
    logic        hs;
    logic        rv_ok;
    logic        rv_keep;
    wcnt_t       demand;
    cnt_t        inflight_d;
    logic        unused_branch_lsb;

    assign unused_branch_lsb = ^ex_branch_addr[1:0];

    always_comb begin
        pop        = !ex_branch_flag && !id_stall_req && (filled_cnt_q != '0);
        // The entry leaving for ID this cycle frees a slot, keeping 1 instr/cycle at depth 2.
        demand     = wcnt_t'(filled_cnt_q) + wcnt_t'(inflight_q) - wcnt_t'(pop);
        imem_req   = !rst && !ex_branch_flag && (demand < wcnt_t'(FBUF_DEPTH));
        imem_addr  = fetch_pc_q;
        hs         = imem_req && imem_ready;
        rv_ok      = imem_rvalid && (inflight_q != '0);
        rv_keep    = rv_ok && (discard_q == '0);
        inflight_d = inflight_q + cnt_t'(hs) - cnt_t'(rv_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q   <= RESET_PC;
            head_q       <= '0;
            fill_q       <= '0;
            tail_q       <= '0;
            filled_cnt_q <= '0;
            inflight_q   <= '0;
            discard_q    <= '0;
        end else if (ex_branch_flag) begin
            fetch_pc_q   <= {ex_branch_addr[31:2], 2'b00};
            head_q       <= '0;
            fill_q       <= '0;
            tail_q       <= '0;
            filled_cnt_q <= '0;
            inflight_q   <= inflight_d;
            // Everything still outstanding belongs to the squashed path.
            discard_q    <= inflight_d;
        end else begin
            if (hs) begin
                tail_q     <= tail_q + ptr_t'(1);
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end
            if (rv_keep) begin
                fill_q <= fill_q + ptr_t'(1);
            end
            if (pop) begin
                head_q <= head_q + ptr_t'(1);
            end
            if (rv_ok && (discard_q != '0)) begin
                discard_q <= discard_q - cnt_t'(1);
            end
            filled_cnt_q <= filled_cnt_q + cnt_t'(rv_keep) - cnt_t'(pop);
            inflight_q   <= inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !ex_branch_flag) begin
            if (hs) begin
                tag_q[tail_q] <= fetch_pc_q;
            end
            if (rv_keep) begin
                data_q[fill_q] <= imem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || ex_branch_flag) begin
            id_pc    <= 32'h0;
            id_instr <= NOP_INSTR;
            id_valid <= 1'b0;
        end else if (!id_stall_req) begin
            if (pop) begin
                id_pc    <= tag_q[head_q];
                id_instr <= data_q[head_q];
                id_valid <= 1'b1;
            end else begin
                id_pc    <= 32'h0;
                id_instr <= NOP_INSTR;
                id_valid <= 1'b0;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt  <= 32'h0;
            perf_bubble_cnt <= 32'h0;
        end else if (ex_branch_flag || !id_stall_req) begin
            if (pop) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end else begin
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            end
        end
    end
`endif

    a_addr_aligned: assert property (@(posedge clk) disable iff (rst)
        imem_addr[1:0] == 2'b00);

    a_capacity: assert property (@(posedge clk) disable iff (rst)
        (wcnt_t'(filled_cnt_q) + wcnt_t'(inflight_q)) <= wcnt_t'(FBUF_DEPTH));

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table, corner sequences, random run vs queue model.
module tb_if_fetch_stage;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          NVEC  = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_stall_req;
    logic        ex_branch_flag;
    logic [31:0] ex_branch_addr;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_valid;

    always #5 clk = ~clk;

    if_fetch_stage #(
        .RESET_PC  (RPC),
        .FBUF_DEPTH(DEPTH),
        .NOP_INSTR (NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .id_stall_req  (id_stall_req),
        .ex_branch_flag(ex_branch_flag),
        .ex_branch_addr(ex_branch_addr),
        .id_pc         (id_pc),
        .id_instr      (id_instr),
        .id_valid      (id_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mem_lat  = 1;

    // Memory: in-order responses, each due at a cycle number.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;
    rsp_t mem_q[$];

    // Reference model: PC, reserved tags, filled data, outstanding / to-drop counts, ID slot.
    logic [31:0] m_pc;
    logic [31:0] m_tags[$];
    logic [31:0] m_data[$];
    int          m_inflight;
    int          m_discard;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_instr;
    logic        m_id_valid;

    typedef struct {
        logic        r;
        logic        stl;
        logic        br;
        logic [31:0] badr;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;
    vec_t vecs[NVEC];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[31:2], 2'b11} ^ 32'h5A00_0000;
    endfunction

    function automatic vec_t mk(input logic r, stl, br, input logic [31:0] badr,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_pc);
        vec_t v;
        v.r = r; v.stl = stl; v.br = br; v.badr = badr;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: cycle budget expired (cycle %0d)", name, cyc);
    endtask

    task automatic model_reset();
        m_pc       = RPC;
        m_tags.delete();
        m_data.delete();
        m_inflight = 0;
        m_discard  = 0;
        m_id_pc    = 32'h0;
        m_id_instr = NOP;
        m_id_valid = 1'b0;
    endtask

    task automatic model_bubble();
        m_id_pc    = 32'h0;
        m_id_instr = NOP;
        m_id_valid = 1'b0;
    endtask

    // One clock: drive at negedge, check fetch side before the edge, ID side after it.
    task automatic do_cycle(input logic r, input logic rdy, input logic stl, input logic br,
                            input logic [31:0] badr, input logic spur,
                            output logic o_req, output logic [31:0] o_addr,
                            output logic o_valid, output logic [31:0] o_pc);
        logic        mem_rv;
        logic        hs;
        logic        pop;
        logic        exp_req;
        logic        rv_ok;
        logic [31:0] hs_addr;
        int          occ;
        int          due;
        rst            = r;
        imem_ready     = rdy;
        id_stall_req   = stl;
        ex_branch_flag = br;
        ex_branch_addr = badr;
        mem_rv         = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_rvalid    = mem_rv || (spur && (mem_q.size() == 0) && (m_inflight == 0));
        imem_rdata     = mem_rv ? instr_of(mem_q[0].addr) : 32'hBAD0_0BAD;
        #1;
        pop     = !br && !stl && (m_data.size() > 0);
        occ     = m_data.size() + m_inflight - (pop ? 1 : 0);
        exp_req = !r && !br && (occ < int'(DEPTH));
        o_req   = imem_req;
        o_addr  = imem_addr;
        check("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) check("imem_addr", imem_addr, m_pc);
        hs      = imem_req && imem_ready;
        hs_addr = imem_addr;
        @(posedge clk);
        #1;
        if (r) begin
            mem_q.delete();
        end else begin
            if (mem_rv) mem_q.delete(0);
            if (hs) begin
                due = cyc + mem_lat;
                if (mem_q.size() > 0 && mem_q[$].due >= due) due = mem_q[$].due + 1;
                mem_q.push_back('{addr: hs_addr, due: due});
            end
        end
        if (r) begin
            model_reset();
        end else begin
            rv_ok = imem_rvalid && (m_inflight > 0);
            if (br) begin
                if (rv_ok) m_inflight--;
                m_tags.delete();
                m_data.delete();
                m_discard = m_inflight;
                m_pc      = badr & 32'hFFFF_FFFC;
                model_bubble();
            end else begin
                if (!stl) begin
                    if (pop) begin
                        m_id_pc    = m_tags.pop_front();
                        m_id_instr = m_data.pop_front();
                        m_id_valid = 1'b1;
                    end else begin
                        model_bubble();
                    end
                end
                if (rv_ok) begin
                    m_inflight--;
                    if (m_discard > 0) m_discard--;
                    else m_data.push_back(imem_rdata);
                end
                if (exp_req && rdy) begin
                    m_tags.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                    m_inflight++;
                end
            end
        end
        check("id_valid", 32'(id_valid), 32'(m_id_valid));
        check("id_pc", id_pc, m_id_pc);
        check("id_instr", id_instr, m_id_instr);
        check("outstanding_le_depth", 32'(mem_q.size() <= int'(DEPTH)), 32'd1);
        o_valid = id_valid;
        o_pc    = id_pc;
        cyc++;
        @(negedge clk);
    endtask

    logic        o_req;
    logic        o_valid;
    logic [31:0] o_addr;
    logic [31:0] o_pc;
    logic        got;
    logic        prev_br;
    logic        rr, rrdy, rstl, rbr, rspur;
    logic [31:0] rbadr;

    task automatic run_until_req(input string name, output logic [31:0] addr);
        logic        q;
        logic        v;
        logic [31:0] a;
        logic [31:0] p;
        addr = 32'hX;
        for (int i = 0; i < 20; i++) begin
            do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, q, a, v, p);
            if (q) begin
                addr = a;
                return;
            end
        end
        bound_fail(name);
    endtask

    task automatic run_until_valid(input string name, output logic [31:0] pc);
        logic        q;
        logic        v;
        logic [31:0] a;
        logic [31:0] p;
        pc = 32'hX;
        for (int i = 0; i < 20; i++) begin
            do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, q, a, v, p);
            if (v) begin
                pc = p;
                return;
            end
        end
        bound_fail(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "simulation time limit");
    end

    initial begin
        //                r  stl br  badr          req addr          vld pc
        vecs[0]  = mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
        vecs[1]  = mk(0, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0);
        vecs[2]  = mk(0, 0, 0, 32'h0,        1, 32'h4,        0, 32'h0);
        vecs[3]  = mk(0, 0, 0, 32'h0,        1, 32'h8,        1, 32'h0);
        vecs[4]  = mk(0, 0, 0, 32'h0,        1, 32'hC,        1, 32'h4);
        vecs[5]  = mk(0, 0, 0, 32'h0,        1, 32'h10,       1, 32'h8);
        vecs[6]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h8);
        vecs[7]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h8);
        vecs[8]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h8);
        vecs[9]  = mk(0, 0, 0, 32'h0,        1, 32'h14,       1, 32'hC);
        vecs[10] = mk(0, 0, 0, 32'h0,        1, 32'h18,       1, 32'h10);
        vecs[11] = mk(0, 1, 1, 32'h203,      0, 32'h0,        0, 32'h0);
        vecs[12] = mk(0, 0, 0, 32'h0,        1, 32'h200,      0, 32'h0);
        vecs[13] = mk(0, 0, 0, 32'h0,        1, 32'h204,      0, 32'h0);
        vecs[14] = mk(0, 0, 0, 32'h0,        1, 32'h208,      1, 32'h200);

        rst            = 1'b1;
        imem_ready     = 1'b1;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        id_stall_req   = 1'b0;
        ex_branch_flag = 1'b0;
        ex_branch_addr = 32'h0;
        model_reset();
        @(negedge clk);

        // Reset, back-to-back fetch, 3-cycle stall, redirect+stall to 0x203.
        mem_lat = 1;
        for (int i = 0; i < NVEC; i++) begin
            do_cycle(vecs[i].r, 1'b1, vecs[i].stl, vecs[i].br, vecs[i].badr, 1'b0,
                     o_req, o_addr, o_valid, o_pc);
            check($sformatf("vec%0d_req", i), 32'(o_req), 32'(vecs[i].e_req));
            if (vecs[i].e_req) check($sformatf("vec%0d_addr", i), o_addr, vecs[i].e_addr);
            check($sformatf("vec%0d_valid", i), 32'(o_valid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d_pc", i), o_pc, vecs[i].e_pc);
        end

        // Redirect to 0x100 with two requests outstanding under 3-cycle memory.
        mem_lat = 3;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (m_inflight == 2) got = 1'b1;
            else do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, o_req, o_addr, o_valid, o_pc);
        end
        if (!got) bound_fail("reach_two_inflight");
        do_cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, o_req, o_addr, o_valid, o_pc);
        check("redir100_bubble", 32'(o_valid), 32'd0);
        run_until_valid("redir100_valid", o_pc);
        check("redir100_first_pc", o_pc, 32'h100);

        // Ready toggling with 3-cycle latency.
        for (int i = 0; i < 40; i++) begin
            do_cycle(1'b0, 1'(i % 2), 1'b0, 1'b0, 32'h0, 1'b0, o_req, o_addr, o_valid, o_pc);
        end

        // PC wrap at the top of the address space.
        mem_lat = 1;
        do_cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, o_req, o_addr, o_valid, o_pc);
        run_until_req("wrap_req0", o_addr);
        check("wrap_addr0", o_addr, 32'hFFFF_FFFC);
        run_until_req("wrap_req1", o_addr);
        check("wrap_addr1", o_addr, 32'h0);
        run_until_valid("wrap_valid0", o_pc);
        check("wrap_pc0", o_pc, 32'hFFFF_FFFC);
        run_until_valid("wrap_valid1", o_pc);
        check("wrap_pc1", o_pc, 32'h0);

        // Reset mid-stream, then stray responses with nothing outstanding.
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, o_req, o_addr, o_valid, o_pc);
        end
        do_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, o_req, o_addr, o_valid, o_pc);
        check("midrst_req", 32'(o_req), 32'd0);
        check("midrst_valid", 32'(o_valid), 32'd0);
        check("midrst_pc", o_pc, 32'h0);
        check("midrst_instr", id_instr, NOP);
        do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, o_req, o_addr, o_valid, o_pc);
        check("postrst_req", 32'(o_req), 32'd1);
        check("postrst_addr", o_addr, RPC);
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, o_req, o_addr, o_valid, o_pc);
        end
        run_until_valid("postrst_valid", o_pc);
        check("postrst_first_pc", o_pc, RPC);

        // Randomised traffic.
        prev_br = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 49) == 0) mem_lat = int'($urandom_range(1, 3));
            rr    = ($urandom_range(0, 249) == 0);
            rrdy  = ($urandom_range(0, 3) != 0);
            rstl  = ($urandom_range(0, 4) == 0);
            rbr   = !prev_br && ($urandom_range(0, 19) == 0);
            rspur = ($urandom_range(0, 9) == 0);
            rbadr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                : ($urandom & 32'h0000_FFFF);
            do_cycle(rr, rrdy, rstl, rbr, rbadr, rspur, o_req, o_addr, o_valid, o_pc);
            prev_br = rbr;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
